// File: rtl/regfile_display_scanner_if.sv
// Register-file viewer bus: flattened register export and selection controls in, displayed value and digits out.
// The master side drives the selection, and the scanner drives the display.
interface regfile_display_scanner_if #(
    parameter int NUM_REGS  = 32,
    parameter int REG_WIDTH = 32,
    parameter int SEL_WIDTH = 5,
    parameter int WIN_WIDTH = 1
);
    logic [NUM_REGS*REG_WIDTH-1:0] i_regs;
    logic [SEL_WIDTH-1:0]          i_sel;
    logic [1:0]                    i_mode;
    logic                          i_step;
    logic [WIN_WIDTH-1:0]          i_window;
    logic [REG_WIDTH-1:0]          o_data;
    logic [SEL_WIDTH-1:0]          o_index;
    logic                          o_changed;
    logic [6:0]                    o_hex3;
    logic [6:0]                    o_hex2;
    logic [6:0]                    o_hex1;
    logic [6:0]                    o_hex0;

    modport master (
        output i_regs, i_sel, i_mode, i_step, i_window,
        input  o_data, o_index, o_changed, o_hex3, o_hex2, o_hex1, o_hex0
    );

    modport slave (
        input  i_regs, i_sel, i_mode, i_step, i_window,
        output o_data, o_index, o_changed, o_hex3, o_hex2, o_hex1, o_hex0
    );
endinterface

// File: rtl/regfile_display_scanner.sv
// Register-file debug viewer: manual/auto-scan/freeze selection driving four active-low hex digits.
// All outputs are registered with 1-cycle latency and no backpressure, so the display updates every cycle.
module regfile_display_scanner #(
    parameter int NUM_REGS    = 32,
    parameter int REG_WIDTH   = 32,
    parameter int SCAN_PERIOD = 50000000,
    parameter int SEL_WIDTH   = 5,
    parameter int WIN_WIDTH   = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    regfile_display_scanner_if.slave  bus
);
    localparam int NUM_WIN = (REG_WIDTH + 15) / 16;
    localparam int PAD_W   = NUM_WIN * 16;
    localparam int CNT_W   = $clog2(SCAN_PERIOD);

    localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(SCAN_PERIOD - 1);
    localparam logic [WIN_WIDTH-1:0] LAST_WIN = WIN_WIDTH'(NUM_WIN - 1);
    localparam logic [SEL_WIDTH:0]   NUM_SEL  = (SEL_WIDTH+1)'(NUM_REGS);

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_AUTO   = 2'b01,
        MODE_FREEZE = 2'b10,
        MODE_ALT    = 2'b11
    } mode_e;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [REG_WIDTH-1:0] reg_arr [NUM_REGS];

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_unpack
        assign reg_arr[k] = bus.i_regs[k*REG_WIDTH +: REG_WIDTH];
    end

    mode_e                mode;
    logic [SEL_WIDTH-1:0] index_q, index_d, index_inc, sel_clamped;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [REG_WIDTH-1:0] data_q, data_d;
    logic                 changed_q, changed_d;
    logic                 after_rst_q;
    logic [WIN_WIDTH-1:0] win_clamped;
    logic [PAD_W-1:0]     padded;
    logic [15:0]          window_d;
    logic [6:0]           hex3_q, hex2_q, hex1_q, hex0_q;

    assign mode = mode_e'(bus.i_mode);

    always_comb begin
        index_inc   = (index_q == LAST_IDX) ? '0 : index_q + SEL_WIDTH'(1);
        sel_clamped = ({1'b0, bus.i_sel} >= NUM_SEL) ? LAST_IDX : bus.i_sel;
        win_clamped = (bus.i_window > LAST_WIN) ? LAST_WIN : bus.i_window;
        index_d     = index_q;
        cnt_d       = '0;
        data_d      = data_q;

        case (mode)
            MODE_AUTO: begin
                // A step landing on the terminal count still advances only once.
                if (bus.i_step || cnt_q == LAST_CNT) begin
                    index_d = index_inc;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                data_d = reg_arr[index_d];
            end
            MODE_FREEZE: begin
                if (bus.i_step) begin
                    index_d = index_inc;
                    data_d  = reg_arr[index_inc];
                end
            end
            default: begin
                index_d = sel_clamped;
                data_d  = reg_arr[sel_clamped];
            end
        endcase

        // The first load after reset is not a change of the displayed value.
        changed_d = (mode != MODE_FREEZE) && !after_rst_q &&
                    (index_d == index_q) && (data_d != data_q);

        padded                  = '0;
        padded[REG_WIDTH-1:0]   = data_d;
        window_d                = padded[win_clamped*16 +: 16];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            index_q     <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            changed_q   <= 1'b0;
            after_rst_q <= 1'b1;
            hex3_q      <= 7'h40;
            hex2_q      <= 7'h40;
            hex1_q      <= 7'h40;
            hex0_q      <= 7'h40;
        end else begin
            index_q     <= index_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            changed_q   <= changed_d;
            after_rst_q <= 1'b0;
            hex3_q      <= seg7(window_d[15:12]);
            hex2_q      <= seg7(window_d[11:8]);
            hex1_q      <= seg7(window_d[7:4]);
            hex0_q      <= seg7(window_d[3:0]);
        end
    end

    assign bus.o_data    = data_q;
    assign bus.o_index   = index_q;
    assign bus.o_changed = changed_q;
    assign bus.o_hex3    = hex3_q;
    assign bus.o_hex2    = hex2_q;
    assign bus.o_hex1    = hex1_q;
    assign bus.o_hex0    = hex0_q;
endmodule

// File: tb/tb_regfile_display_scanner.sv
// Bench for regfile_display_scanner: two configurations (32x32 and 20x24) share one random stimulus stream,
// with a queue-based scoreboard fed by a reference model and checked by a separate monitor.
module tb_regfile_display_scanner;
    localparam int PER = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_display_scanner_if #(.NUM_REGS(32), .REG_WIDTH(32), .SEL_WIDTH(5), .WIN_WIDTH(1)) bus_a();
    regfile_display_scanner_if #(.NUM_REGS(20), .REG_WIDTH(24), .SEL_WIDTH(5), .WIN_WIDTH(1)) bus_b();

    regfile_display_scanner #(.NUM_REGS(32), .REG_WIDTH(32), .SCAN_PERIOD(PER), .SEL_WIDTH(5), .WIN_WIDTH(1))
        dut_a (.i_clk(clk), .i_rst(rst), .bus(bus_a));
    regfile_display_scanner #(.NUM_REGS(20), .REG_WIDTH(24), .SCAN_PERIOD(PER), .SEL_WIDTH(5), .WIN_WIDTH(1))
        dut_b (.i_clk(clk), .i_rst(rst), .bus(bus_b));

    logic [31:0] regs_m [32];

    always_comb begin
        bus_a.i_regs = '0;
        for (int k = 0; k < 32; k++) bus_a.i_regs[k*32 +: 32] = regs_m[k];
    end
    always_comb begin
        bus_b.i_regs = '0;
        for (int k = 0; k < 20; k++) bus_b.i_regs[k*24 +: 24] = regs_m[k][23:0];
    end

    typedef struct {
        int          idx;
        logic [31:0] data;
        bit          chg;
        logic [27:0] hex;
        int          cnt;
        bit          fresh;
    } mstate_t;

    mstate_t ma, mb;
    mstate_t qa[$];
    mstate_t qb[$];
    int  n_chk  = 0;
    int  n_fail = 0;
    bit  done   = 1'b0;

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    // Reference behaviour for one clock edge, stated directly from the viewer's rules.
    function automatic mstate_t model_step(mstate_t s, int nr, int rw, bit r, int mode, bit stp,
                                           int sel, int win);
        mstate_t     n     = s;
        logic [31:0] mask  = (rw >= 32) ? 32'hFFFF_FFFF : ((32'h1 << rw) - 32'h1);
        int          nwin  = (rw + 15) / 16;
        int          w;
        logic [15:0] v;
        bit          frz   = (mode == 2);
        if (r) begin
            n.idx = 0; n.data = 0; n.chg = 0; n.cnt = 0; n.fresh = 1;
            n.hex = {7'h40, 7'h40, 7'h40, 7'h40};
            return n;
        end
        if (mode == 1) begin
            if (stp || s.cnt == PER - 1) begin
                n.idx = (s.idx + 1) % nr;
                n.cnt = 0;
            end else begin
                n.cnt = s.cnt + 1;
            end
            n.data = regs_m[n.idx] & mask;
        end else if (frz) begin
            n.cnt = 0;
            if (stp) begin
                n.idx  = (s.idx + 1) % nr;
                n.data = regs_m[n.idx] & mask;
            end
        end else begin
            n.cnt  = 0;
            n.idx  = (sel < nr) ? sel : nr - 1;
            n.data = regs_m[n.idx] & mask;
        end
        n.chg   = !frz && !s.fresh && (n.idx == s.idx) && (n.data != s.data);
        n.fresh = 0;
        w = (win > nwin - 1) ? nwin - 1 : win;
        v = 16'(n.data >> (16 * w));
        n.hex = {seg(v[15:12]), seg(v[11:8]), seg(v[7:4]), seg(v[3:0])};
        return n;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and queue the expected result of the next rising edge.
    task automatic tick(input bit r, input logic [1:0] mode, input bit stp, input int sel, input int win);
        rst            = r;
        bus_a.i_mode   = mode;  bus_b.i_mode   = mode;
        bus_a.i_step   = stp;   bus_b.i_step   = stp;
        bus_a.i_sel    = 5'(sel); bus_b.i_sel  = 5'(sel);
        bus_a.i_window = 1'(win); bus_b.i_window = 1'(win);
        ma = model_step(ma, 32, 32, r, int'(mode), stp, sel, win);
        mb = model_step(mb, 20, 24, r, int'(mode), stp, sel, win);
        qa.push_back(ma);
        qb.push_back(mb);
        @(negedge clk);
    endtask

    // Monitor: every rising edge produces a display update for each instance.
    initial begin : monitor
        mstate_t ea, eb;
        forever begin
            @(posedge clk);
            #1;
            if (done) break;
            if (qa.size() == 0 || qb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL scoreboard_underflow: got empty queue expected entry at %0t", $time);
            end else begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                chk("A.index",   64'(bus_a.o_index), 64'(ea.idx));
                chk("A.data",    64'(bus_a.o_data), 64'(ea.data));
                chk("A.changed", 64'(bus_a.o_changed), 64'(ea.chg));
                chk("A.hex",     64'({bus_a.o_hex3, bus_a.o_hex2, bus_a.o_hex1, bus_a.o_hex0}), 64'(ea.hex));
                chk("B.index",   64'(bus_b.o_index), 64'(eb.idx));
                chk("B.data",    64'(bus_b.o_data), 64'(eb.data[23:0]));
                chk("B.changed", 64'(bus_b.o_changed), 64'(eb.chg));
                chk("B.hex",     64'({bus_b.o_hex3, bus_b.o_hex2, bus_b.o_hex1, bus_b.o_hex0}), 64'(eb.hex));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : driver
        int mode, sel, win;
        for (int k = 0; k < 32; k++) regs_m[k] = 32'(k) * 32'h0101_0101;
        ma = '{default: 0};
        mb = '{default: 0};

        tick(1, 2'b00, 0, 0, 0);
        tick(1, 2'b00, 0, 0, 0);

        // Manual view of an "AbCd"/"1234" value in both windows.
        regs_m[3] = 32'h1234_ABCD;
        tick(0, 2'b00, 0, 3, 0);
        chk("t1.hex_lo", 64'({bus_a.o_hex3, bus_a.o_hex2, bus_a.o_hex1, bus_a.o_hex0}),
            64'({7'h08, 7'h03, 7'h46, 7'h21}));
        tick(0, 2'b00, 0, 3, 1);
        chk("t1.hex_hi", 64'({bus_a.o_hex3, bus_a.o_hex2, bus_a.o_hex1, bus_a.o_hex0}),
            64'({7'h79, 7'h24, 7'h30, 7'h19}));

        // Change pulse on the same index; none when the index moves.
        regs_m[31] = 32'd5;
        regs_m[30] = 32'd77;
        tick(0, 2'b00, 0, 31, 0);
        tick(0, 2'b00, 0, 31, 0);
        regs_m[31] = 32'd6;
        tick(0, 2'b00, 0, 31, 0);
        chk("t2.changed", 64'(bus_a.o_changed), 64'd1);
        tick(0, 2'b00, 0, 31, 0);
        tick(0, 2'b00, 0, 30, 0);
        chk("t2.no_change_on_move", 64'(bus_a.o_changed), 64'd0);

        // Auto scan from 30 with wrap, plus a step.
        for (int i = 0; i < 18; i++) tick(0, 2'b01, (i == 14), 0, 0);

        // Freeze holds the captured value, then a step captures the next register.
        regs_m[5] = 32'hAAAA_0000;
        regs_m[6] = 32'h0000_6666;
        tick(0, 2'b00, 0, 5, 1);
        tick(0, 2'b10, 0, 5, 1);
        regs_m[5] = 32'hFFFF_FFFF;
        tick(0, 2'b10, 0, 5, 1);
        tick(0, 2'b10, 0, 5, 1);
        chk("t4.frozen_data", 64'(bus_a.o_data), 64'h0000_0000_AAAA_0000);
        tick(0, 2'b10, 1, 5, 0);
        tick(0, 2'b10, 0, 5, 0);
        tick(0, 2'b00, 0, 5, 0);

        // Reset in the middle of an auto scan, then a full period from index 0.
        tick(0, 2'b00, 0, 7, 0);
        tick(0, 2'b01, 0, 7, 0);
        tick(0, 2'b01, 0, 7, 0);
        tick(1, 2'b01, 0, 7, 0);
        chk("t5.rst_index", 64'(bus_a.o_index), 64'd0);
        for (int i = 0; i < 10; i++) tick(0, 2'b01, 0, 0, 0);

        // Out-of-range select clamps on the 20-register instance; upper window is zero padded.
        regs_m[19] = 32'h00AB_CDEF;
        tick(0, 2'b00, 0, 25, 1);
        chk("t6.clamp_index", 64'(bus_b.o_index), 64'd19);
        chk("t6.hex_pad", 64'({bus_b.o_hex3, bus_b.o_hex2, bus_b.o_hex1, bus_b.o_hex0}),
            64'({7'h40, 7'h40, 7'h08, 7'h03}));

        // Randomised traffic.
        mode = 0; sel = 0; win = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) mode = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0)  sel  = $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0)  win  = $urandom_range(0, 1);
            if ($urandom_range(0, 1) == 0)  regs_m[$urandom_range(0, 31)] = $urandom;
            if ($urandom_range(0, 3) == 0)  regs_m[ma.idx] = $urandom_range(0, 3);
            tick(($urandom_range(0, 299) == 0), 2'(mode), ($urandom_range(0, 5) == 0), sel, win);
        end

        done = 1'b1;
        @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
